// File: rtl/uart_field_receiver.sv
// Oversampling UART receiver that packs characters into delimited fields.
// Build option UART_PARITY_EN adds an even-parity bit after the data bits.
module uart_field_receiver #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int NUM_FIELDS  = 2,
  parameter int FIELD_BYTES = 4,
  parameter logic [7:0] DELIM = 8'd44,
  parameter logic [7:0] TERM  = 8'd64,
  localparam int FIW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1,
  localparam int FW  = NUM_FIELDS * FIELD_BYTES * 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rxd,
  input  logic                 clear,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 byte_valid,
  output logic [FW-1:0]        fields,
  output logic [FIW-1:0]       field_idx,
  output logic                 frame_done,
  output logic                 locked,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int FB8     = FIELD_BYTES * 8;

  localparam logic [CW-1:0]  DLAST = CW'(DIV - 1);
  localparam logic [SW-1:0]  HALF  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0]  LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]     BLAST = 3'(DATA_BITS - 1);
  localparam logic [FIW-1:0] ILAST = FIW'(NUM_FIELDS - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t                state;
  logic                  rxd_m;
  logic                  rxd_s;
  logic [CW-1:0]         dcnt;
  logic                  tick;
  logic [SW-1:0]         scnt;
  logic [2:0]            bcnt;
  logic [DATA_BITS-1:0]  shreg;
  logic                  stop_smp;
  logic                  par_bad;
  logic                  accept;
  logic [7:0]            b8;
  logic [FB8-1:0]        cur;
  logic [FB8-1:0]        nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dcnt <= '0;
    else          dcnt <= tick ? '0 : dcnt + 1'b1;
  end

  assign tick = (dcnt == DLAST);

`ifdef UART_PARITY_EN
  logic pbit;
  logic perr_q;
  assign par_bad    = ^{shreg, pbit};
  assign parity_err = perr_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    stop_smp = tick && (state == S_STOP) && (scnt == LAST);
    accept   = stop_smp && rxd_s && !par_bad;
    b8       = '0;
    b8[DATA_BITS-1:0] = shreg;
    cur      = fields[int'(field_idx)*FB8 +: FB8];
    nxt      = FB8'({cur, b8});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      scnt       <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      pbit       <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      byte_valid <= accept;
      frame_err  <= stop_smp && !rxd_s;
`ifdef UART_PARITY_EN
      perr_q     <= stop_smp && rxd_s && par_bad;
`endif
      if (accept) byte_data <= shreg;
      if (tick) begin
        case (state)
          S_IDLE: begin
            if (!rxd_s) begin
              scnt  <= '0;
              state <= S_START;
            end
          end
          S_START: begin
            scnt <= scnt + 1'b1;
            if (scnt == HALF) begin
              scnt  <= '0;
              bcnt  <= '0;
              state <= rxd_s ? S_IDLE : S_DATA;
            end
          end
          S_DATA: begin
            scnt <= scnt + 1'b1;
            if (scnt == LAST) begin
              shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
              bcnt  <= bcnt + 1'b1;
              if (bcnt == BLAST) begin
`ifdef UART_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end
            end
          end
`ifdef UART_PARITY_EN
          S_PARITY: begin
            scnt <= scnt + 1'b1;
            if (scnt == LAST) begin
              pbit  <= rxd_s;
              state <= S_STOP;
            end
          end
`endif
          S_STOP: begin
            scnt <= scnt + 1'b1;
            // back to idle at mid-stop so the next start edge is caught early
            if (scnt == LAST) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fields     <= '0;
      field_idx  <= '0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (clear) begin
        fields    <= '0;
        field_idx <= '0;
        locked    <= 1'b0;
      end else if (accept && !locked) begin
        unique case (1'b1)
          (b8 == TERM): begin
            locked     <= 1'b1;
            frame_done <= 1'b1;
          end
          (b8 == DELIM): begin
            if (field_idx != ILAST) field_idx <= field_idx + 1'b1;
          end
          default: fields[int'(field_idx)*FB8 +: FB8] <= nxt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_field_receiver.sv
// Bench for uart_field_receiver: serial stimulus against a field model.
// Clock is scaled so one bit is 48 clocks (divider 3, 16x oversample).
module tb_uart_field_receiver;

  localparam int BAUD = 115200;
  localparam int OS   = 16;
  localparam int CLKF = BAUD * OS * 3;
  localparam int BITC = 48;
  localparam int NF   = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            rxd = 1'b1;
  logic            clear = 1'b0;
  logic [7:0]      byte_data;
  logic            byte_valid;
  logic [NF*32-1:0] fields;
  logic [0:0]      field_idx;
  logic            frame_done;
  logic            locked;
  logic            frame_err;
  logic            parity_err;

  uart_field_receiver #(
    .CLK_FREQ(CLKF), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
    .NUM_FIELDS(NF), .FIELD_BYTES(4), .DELIM(8'd44), .TERM(8'd64)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rxd(rxd), .clear(clear),
    .byte_data(byte_data), .byte_valid(byte_valid), .fields(fields),
    .field_idx(field_idx), .frame_done(frame_done), .locked(locked),
    .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int bv_cnt = 0;
  int fd_cnt = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  bit par_flip = 1'b0;

  always @(negedge clk) begin
    if (byte_valid) bv_cnt++;
    if (frame_done) fd_cnt++;
    if (frame_err)  fe_cnt++;
    if (parity_err) pe_cnt++;
  end

  logic [31:0] mf [NF];
  int          midx;
  bit          mlock;

  function automatic void model_reset();
    for (int k = 0; k < NF; k++) mf[k] = '0;
    midx  = 0;
    mlock = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (mlock) return;
    if (b == 8'd64) mlock = 1'b1;
    else if (b == 8'd44) begin
      if (midx < NF - 1) midx++;
    end else mf[midx] = (mf[midx] << 8) | 32'(b);
  endfunction

  function automatic logic [NF*32-1:0] model_flat();
    logic [NF*32-1:0] v;
    for (int k = 0; k < NF; k++) v[k*32 +: 32] = mf[k];
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BITC) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rxd = (^b) ^ par_flip;
    repeat (BITC) @(negedge clk);
`endif
    if (stop_ok) begin
      rxd = 1'b1;
      repeat (BITC) @(negedge clk);
    end else begin
      rxd = 1'b0;
      repeat (30) @(negedge clk);
      rxd = 1'b1;
      repeat (2 * BITC) @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], 1'b1);
      model_byte(s[i]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({byte_valid, frame_done, frame_err, parity_err, locked} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {byte_valid, frame_done, frame_err, parity_err, locked});
    end
    checks++;
    if ({byte_data, fields, field_idx} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h/%h expected 0",
               byte_data, fields, field_idx);
    end
    reset_n = 1'b1;
    repeat (2 * BITC) @(negedge clk);
    checks++;
    if (byte_valid !== 1'b0 || fields !== '0) begin
      errors++;
      $display("FAIL idle_line: got bv=%b fields=%h expected 0", byte_valid, fields);
    end
    model_reset();
  endtask

  task automatic test_frame();
    int bv0 = bv_cnt;
    int fd0 = fd_cnt;
    send_str("12,34@");
    checks++;
    if (fields !== 64'h00003334_00003132) begin
      errors++;
      $display("FAIL frame_fields: got %h expected %h", fields, 64'h00003334_00003132);
    end
    checks++;
    if (field_idx !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL frame_state: got idx=%b lock=%b expected 1 1", field_idx, locked);
    end
    checks++;
    if (bv_cnt - bv0 != 6 || fd_cnt - fd0 != 1) begin
      errors++;
      $display("FAIL frame_strobes: got bv=%0d fd=%0d expected 6 1",
               bv_cnt - bv0, fd_cnt - fd0);
    end
    checks++;
    if (byte_data !== 8'h40) begin
      errors++;
      $display("FAIL frame_last_byte: got %h expected 40", byte_data);
    end
  endtask

  task automatic test_locked_clear();
    int bv0 = bv_cnt;
    send_str("9");
    checks++;
    if (byte_data !== 8'h39 || bv_cnt - bv0 != 1) begin
      errors++;
      $display("FAIL locked_byte: got %h n=%0d expected 39 n=1", byte_data, bv_cnt - bv0);
    end
    checks++;
    if (fields !== model_flat() || locked !== 1'b1) begin
      errors++;
      $display("FAIL locked_fields: got %h lock=%b expected %h lock=1",
               fields, locked, model_flat());
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    checks++;
    if (fields !== '0 || field_idx !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL clear: got %h idx=%b lock=%b expected 0",
               fields, field_idx, locked);
    end
  endtask

  task automatic test_overflow();
    send_str("12345");
    checks++;
    if (fields[31:0] !== 32'h32333435) begin
      errors++;
      $display("FAIL overflow: got %h expected 32333435", fields[31:0]);
    end
    send_str(",,,7");
    checks++;
    if (fields !== 64'h00000037_32333435 || field_idx !== 1'b1) begin
      errors++;
      $display("FAIL extra_delim: got %h idx=%b expected %h idx=1",
               fields, field_idx, 64'h00000037_32333435);
    end
  endtask

  task automatic test_random();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    for (int n = 0; n < 14; n++) begin
      int r = $urandom_range(0, 11);
      int bv0 = bv_cnt;
      logic [7:0] b;
      b = (r == 0) ? 8'd44 : (r == 1 && n > 8) ? 8'd64 : 8'($urandom_range(0, 255));
      send_byte(b, 1'b1);
      model_byte(b);
      checks++;
      if (byte_data !== b || bv_cnt - bv0 != 1) begin
        errors++;
        $display("FAIL rand_byte[%0d]: got %h n=%0d expected %h n=1",
                 n, byte_data, bv_cnt - bv0, b);
      end
      checks++;
      if (fields !== model_flat() || field_idx !== 1'(midx) || locked !== mlock) begin
        errors++;
        $display("FAIL rand_fields[%0d]: got %h idx=%b lock=%b expected %h idx=%0d lock=%b",
                 n, fields, field_idx, locked, model_flat(), midx, mlock);
      end
    end
  endtask

  task automatic test_glitch();
    int bv0 = bv_cnt;
    int fe0 = fe_cnt;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    rxd = 1'b0;
    repeat (14) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * BITC) @(negedge clk);
    checks++;
    if (bv_cnt != bv0 || fe_cnt != fe0) begin
      errors++;
      $display("FAIL glitch: got bv=%0d fe=%0d expected 0 0", bv_cnt - bv0, fe_cnt - fe0);
    end
    send_byte(8'h55, 1'b1);
    model_byte(8'h55);
    checks++;
    if (byte_data !== 8'h55 || bv_cnt - bv0 != 1 || fields !== model_flat()) begin
      errors++;
      $display("FAIL after_glitch: got %h n=%0d f=%h expected 55 n=1 f=%h",
               byte_data, bv_cnt - bv0, fields, model_flat());
    end
  endtask

  task automatic test_frame_err();
    int bv0 = bv_cnt;
    int fe0 = fe_cnt;
    logic [NF*32-1:0] f0 = model_flat();
    send_byte(8'hA5, 1'b0);
    checks++;
    if (fe_cnt - fe0 != 1 || bv_cnt != bv0) begin
      errors++;
      $display("FAIL frame_err: got fe=%0d bv=%0d expected 1 0", fe_cnt - fe0, bv_cnt - bv0);
    end
    checks++;
    if (fields !== f0 || byte_data !== 8'h55) begin
      errors++;
      $display("FAIL frame_err_keep: got %h/%h expected %h/55", fields, byte_data, f0);
    end
  endtask

  task automatic test_reset_mid();
    int bv0;
    fork
      send_byte(8'h41, 1'b1);
      begin
        repeat (BITC * 4 + BITC / 2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({byte_valid, frame_done, frame_err, parity_err, locked} !== 5'b0 ||
            {byte_data, fields, field_idx} !== '0) begin
          errors++;
          $display("FAIL async_reset: got bd=%h f=%h idx=%b expected 0",
                   byte_data, fields, field_idx);
        end
      end
    join
    reset_n = 1'b1;
    model_reset();
    repeat (BITC) @(negedge clk);
    bv0 = bv_cnt;
    send_byte(8'h41, 1'b1);
    model_byte(8'h41);
    checks++;
    if (byte_data !== 8'h41 || bv_cnt - bv0 != 1 || fields !== model_flat()) begin
      errors++;
      $display("FAIL post_reset_byte: got %h n=%0d f=%h expected 41 n=1 f=%h",
               byte_data, bv_cnt - bv0, fields, model_flat());
    end
  endtask

  task automatic test_parity();
`ifdef UART_PARITY_EN
    int bv0 = bv_cnt;
    int pe0 = pe_cnt;
    par_flip = 1'b0;
    send_byte(8'h41, 1'b1);
    checks++;
    if (bv_cnt - bv0 != 1 || pe_cnt != pe0) begin
      errors++;
      $display("FAIL parity_good: got bv=%0d pe=%0d expected 1 0", bv_cnt - bv0, pe_cnt - pe0);
    end
    bv0 = bv_cnt;
    par_flip = 1'b1;
    send_byte(8'h41, 1'b1);
    par_flip = 1'b0;
    checks++;
    if (bv_cnt != bv0 || pe_cnt - pe0 != 1) begin
      errors++;
      $display("FAIL parity_bad: got bv=%0d pe=%0d expected 0 1", bv_cnt - bv0, pe_cnt - pe0);
    end
`else
    checks++;
    if (pe_cnt != 0) begin
      errors++;
      $display("FAIL parity_tied: got %0d pulses expected 0", pe_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_frame();
    test_locked_clear();
    test_overflow();
    test_random();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_field_receiver.md
Name: uart_field_receiver

Overview:
Parametrised UART receiver with a built-in field parser, and the successor to the fixed 8N1 two-field receiver.
- Oversamples rxd, validates start and stop bits, and emits each received byte with a one-cycle strobe.
- Packs non-control bytes into NUM_FIELDS shift registers; DELIM advances to the next field and TERM closes the frame.
- Sits between the board RS-232 pin and the display/command logic.

Parameters:
- CLK_FREQ, 50000000: system clock in Hz.
- BAUD, 115200: line rate in bit/s.
- OVERSAMPLE, 16: samples per bit (power of two, >= 8).
- DATA_BITS, 8: data bits per character (5..8).
- NUM_FIELDS, 2: number of field registers (>= 1).
- FIELD_BYTES, 4: bytes held per field.
- DELIM, 8'd44: field delimiter (',').
- TERM, 8'd64: frame terminator ('@').

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- rxd, in, 1: serial input, idle high, asynchronous to clk.
- clear, in, 1: synchronous; clears fields, field index and lock.
- byte_data, out, DATA_BITS: last received character.
- byte_valid, out, 1: one-cycle strobe, byte_data is new.
- fields, out, NUM_FIELDS*FIELD_BYTES*8: field k occupies bits [k*FIELD_BYTES*8 +: FIELD_BYTES*8].
- field_idx, out, clog2(NUM_FIELDS) (min 1): index of the active field.
- frame_done, out, 1: one-cycle strobe when TERM is received.
- locked, out, 1: a frame is complete and further bytes are ignored.
- frame_err, out, 1: one-cycle strobe on a bad stop bit.
- parity_err, out, 1: one-cycle strobe on a parity mismatch (see Optional Feature).

Behaviour:
Reset (reset_n=0, async):
- All outputs, fields, field_idx, the divider and the FSM go to 0; locked=0.
- Synchroniser flops go to 1 (idle).

Input synchroniser and tick generator:
- rxd passes through a 2-flop synchroniser; all logic uses the synchronised value.
- Tick generator: a counter wraps at DIV = CLK_FREQ/(BAUD*OVERSAMPLE) (integer divide, min 1) and produces a 1-cycle tick.
- The counter free-runs and only resets on reset_n.

FSM, advancing on ticks with a sample counter scnt of width log2(OVERSAMPLE):
- IDLE: on synchronised rxd=0, scnt<=0 and go to START.
- START: at scnt=OVERSAMPLE/2-1, sample rxd.
  - rxd=1: false start, return to IDLE with no output.
  - rxd=0: reset scnt and go to DATA.
- DATA: sample at every scnt=OVERSAMPLE-1 (mid-bit). Shift LSB-first, DATA_BITS samples, then go to PARITY (if enabled) or STOP.
- PARITY (only when compiled in): sample one bit, then go to STOP.
- STOP: sample at mid-bit.
  - rxd=0: pulse frame_err, discard the byte.
  - rxd=1: byte accepted.
  - Either way go to IDLE immediately, so the FSM can resync on the next start edge within half a bit.

Accepted byte:
- byte_data and byte_valid (=1) are registered on the clk after the stop sample.
- The byte is processed for fields on that same edge.
- The byte strobe appears even while locked.

Field parsing, ignored when locked=1 (zero-extend to 8 bits when DATA_BITS<8):
- byte==TERM: locked<=1, frame_done pulses; fields are unchanged.
- byte==DELIM: field_idx<=field_idx+1, saturating at NUM_FIELDS-1. Extra delimiters are ignored; later bytes go to the last field.
- Any other byte: field[field_idx] <= {field[field_idx][FIELD_BYTES*8-9:0], byte}. The oldest byte is discarded on overflow.

clear:
- Zeroes fields, field_idx and locked on the next clk.
- Does not disturb a byte in flight.
- If clear coincides with byte acceptance, clear wins and the byte strobe still appears.

Other rules:
- reset_n asserted mid-byte aborts reception; after release, the FSM waits for the next falling edge.
- frame_err and parity_err never update fields.

Optional Feature:
Macro UART_PARITY_EN.
- Defined: one even-parity bit follows the data bits. On a mismatch, parity_err pulses together with the would-be byte_valid cycle, byte_valid stays 0, and the byte is discarded.
- Undefined: no parity state exists, the frame is start+DATA_BITS+stop, and parity_err is tied 0.

Test Plan:
- Send "12,34@" at 115200 8N1 → fields[31:0]=32'h00003132, fields[63:32]=32'h00003334, field_idx=1, frame_done pulses once, locked=1, byte_valid pulses 6 times.
- While locked, send "9" → byte_valid pulses with byte_data=8'h39; fields unchanged. Then clear=1 for one cycle → fields=0, field_idx=0, locked=0.
- Send "12345" → field0=32'h32333435 (the '1' is shifted out). Send ",,,7" with NUM_FIELDS=2 → field1=32'h00000037, field_idx=1.
- Low glitch on rxd of 0.3 bit → no byte_valid, FSM back in IDLE. A frame with stop bit=0 → frame_err pulses once, fields unchanged.
- reset_n=0 during bit 3 of a byte → all outputs 0 asynchronously; the next full byte 8'h41 is received correctly.
- UART_PARITY_EN defined: 8'h41 with parity=0 → accepted; 8'h41 with parity=1 → parity_err pulses, byte_valid stays 0.
